// File: rtl/adpcm_seq.sv
// adpcm_seq: stream-to-core sequencer for one adpcm codec core.
// Drives the core's toggle-request / ack(idle) handshake from valid/ready
// streams. Encode packs two 4-bit codes per output byte, low nibble first.
// Decode unpacks one code byte into two PCM samples, low nibble first.
// Optional feature macro: ADPCM_SEQ_FLUSH_EN adds a 'flush' input that
// emits a pending half byte (upper nibble zero).
module adpcm_seq #(
    parameter int ACK_TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        mode,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        core_req,
    input  logic        core_ack,
    output logic        core_sel_rx,
    output logic [15:0] core_rx_pcm,
    output logic [3:0]  core_rx_adpcm,
    input  logic [15:0] core_tx_pcm,
    input  logic [3:0]  core_tx_adpcm,
`ifdef ADPCM_SEQ_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic        err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4,
        ST_OUT     = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic          core_req_r, core_req_s;
    logic          sel_r, sel_s;
    logic [15:0]   rx_pcm_r, rx_pcm_s;
    logic [3:0]    rx_adpcm_r, rx_adpcm_s;
    logic [15:0]   m_data_r, m_data_s;
    logic          m_valid_r, m_valid_s;
    logic          err_r, err_s;
    logic          nib_cnt_r, nib_cnt_s;
    logic          nib_sel_r, nib_sel_s;
    logic [3:0]    hold_hi_r, hold_hi_s;
    logic [3:0]    byte_lo_r, byte_lo_s;
    logic [TW-1:0] timer_r, timer_s;
    logic          eff_mode_s;
    logic          flush_hit_s;

    // Flush applies only to a pending half byte while idle.
`ifdef ADPCM_SEQ_FLUSH_EN
    assign flush_hit_s = flush && nib_cnt_r && (state_r == ST_IDLE);
`else
    assign flush_hit_s = 1'b0;
`endif

    assign s_ready       = enable && (state_r == ST_IDLE) && !flush_hit_s;
    assign m_valid       = m_valid_r;
    assign m_data        = m_data_r;
    assign core_req      = core_req_r;
    assign core_sel_rx   = sel_r;
    assign core_rx_pcm   = rx_pcm_r;
    assign core_rx_adpcm = rx_adpcm_r;
    assign err           = err_r;
    assign busy          = (state_r != ST_IDLE) || nib_cnt_r;

    // Mode is only re-latched when no half byte is pending.
    assign eff_mode_s = nib_cnt_r ? sel_r : mode;

    // Next-state and next-datapath computation for the sequencer FSM.
    always_comb begin
        state_s    = state_r;
        core_req_s = core_req_r;
        sel_s      = sel_r;
        rx_pcm_s   = rx_pcm_r;
        rx_adpcm_s = rx_adpcm_r;
        m_data_s   = m_data_r;
        err_s      = err_r;
        nib_cnt_s  = nib_cnt_r;
        nib_sel_s  = nib_sel_r;
        hold_hi_s  = hold_hi_r;
        byte_lo_s  = byte_lo_r;
        timer_s    = timer_r;

        case (state_r)
            ST_IDLE: begin
                if (flush_hit_s) begin
                    m_data_s  = {8'h00, 4'h0, byte_lo_r};
                    nib_cnt_s = 1'b0;
                    state_s   = ST_OUT;
                end else if (s_valid) begin
                    hold_hi_s = s_data[7:4];
                    sel_s     = eff_mode_s;
                    err_s     = 1'b0;
                    if (eff_mode_s) begin
                        rx_adpcm_s = s_data[3:0];
                        nib_sel_s  = 1'b0;
                    end else begin
                        rx_pcm_s = s_data;
                    end
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (core_ack) begin
                    core_req_s = ~core_req_r;
                    timer_s    = {TW{1'b0}};
                    state_s    = ST_WAIT_LO;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT_LO: begin
                if (!core_ack) begin
                    state_s = ST_WAIT_HI;
                end else if (timer_r == TW'(ACK_TIMEOUT)) begin
                    err_s     = 1'b1;
                    nib_cnt_s = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_WAIT_HI: begin
                if (core_ack) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT_HI;
                end
            end
            ST_DONE: begin
                if (sel_r) begin
                    m_data_s = core_tx_pcm;
                    state_s  = ST_OUT;
                end else if (!nib_cnt_r) begin
                    byte_lo_s = core_tx_adpcm;
                    nib_cnt_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    m_data_s  = {8'h00, core_tx_adpcm, byte_lo_r};
                    nib_cnt_s = 1'b0;
                    state_s   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    if (sel_r && !nib_sel_r) begin
                        nib_sel_s  = 1'b1;
                        rx_adpcm_s = hold_hi_r;
                        state_s    = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_s    = ST_IDLE;
            core_req_s = 1'b0;
            sel_s      = 1'b0;
            rx_pcm_s   = 16'h0000;
            rx_adpcm_s = 4'h0;
            m_data_s   = 16'h0000;
            err_s      = 1'b0;
            nib_cnt_s  = 1'b0;
            nib_sel_s  = 1'b0;
            hold_hi_s  = 4'h0;
            byte_lo_s  = 4'h0;
            timer_s    = {TW{1'b0}};
        end else begin
            state_s = state_s;
        end

        m_valid_s = (state_s == ST_OUT);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            core_req_r <= 1'b0;
            sel_r      <= 1'b0;
            rx_pcm_r   <= 16'h0000;
            rx_adpcm_r <= 4'h0;
            m_data_r   <= 16'h0000;
            m_valid_r  <= 1'b0;
            err_r      <= 1'b0;
            nib_cnt_r  <= 1'b0;
            nib_sel_r  <= 1'b0;
            hold_hi_r  <= 4'h0;
            byte_lo_r  <= 4'h0;
            timer_r    <= {TW{1'b0}};
        end else begin
            state_r    <= state_s;
            core_req_r <= core_req_s;
            sel_r      <= sel_s;
            rx_pcm_r   <= rx_pcm_s;
            rx_adpcm_r <= rx_adpcm_s;
            m_data_r   <= m_data_s;
            m_valid_r  <= m_valid_s;
            err_r      <= err_s;
            nib_cnt_r  <= nib_cnt_s;
            nib_sel_r  <= nib_sel_s;
            hold_hi_r  <= hold_hi_s;
            byte_lo_r  <= byte_lo_s;
            timer_r    <= timer_s;
        end
    end

endmodule
